ring_writer: RTL

RING_WRITER -- requirements
Module: ring_writer

---
 rtl/ring_writer_pkg.sv | 20 ++
 rtl/ring_writer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ring_writer_pkg.sv
// Shared correlator definitions: ring writer state encoding and drop-counter sizing.
package ring_writer_pkg;

    // Ring fill phase: FILL until the ring first holds SIZE samples, then RUN.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } rw_state_e;

    localparam int unsigned DROP_W = 8;

    // Saturating increment for the suppressed-frame counter.
    function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] cnt);
        if (cnt == {DROP_W{1'b1}}) begin
            return cnt;
        end
        return cnt + DROP_W'(1);
    endfunction

endpackage

// File: rtl/ring_writer.sv
// Ring writer: streams samples into an external dpram ring and announces
// correlation windows every FRAME writes once the ring has filled.
module ring_writer
    import ring_writer_pkg::*;
#(
    parameter  int unsigned BITS  = 16,
    parameter  int unsigned SIZE  = 256,
    parameter  int unsigned FRAME = 64,
    localparam int unsigned AW    = $clog2(SIZE),
    localparam int unsigned FILLW = AW + 1,
    localparam int unsigned FW    = (FRAME > 1) ? $clog2(FRAME) : 1
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BITS-1:0]   in_data,
    input  logic              busy,
    input  logic              clr_drop,
    output logic              we,
    output logic [AW-1:0]     waddr,
    output logic [BITS-1:0]   wdata,
    output logic              frame,
    output logic [AW-1:0]     base,
    output logic              dropped,
    output logic [DROP_W-1:0] drop_cnt
);

    rw_state_e         r_state;
    rw_state_e         w_state_nxt;

    logic [AW-1:0]     r_ptr;
    logic [FILLW-1:0]  r_fill;
    logic [FW-1:0]     r_fcnt;

    logic              r_we;
    logic [AW-1:0]     r_waddr;
    logic [BITS-1:0]   r_wdata;
    logic              r_frame;
    logic [AW-1:0]     r_base;
    logic              r_dropped;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_fill_last;
    logic              w_frame_wrap;
    logic              w_cand;
    logic              w_fire;
    logic              w_drop;

    // Event decode for the sample being accepted this cycle. busy is sampled
    // together with the sample, so frame/drop appear alongside its we cycle.
    always_comb begin
        w_fill_last  = (r_fill == FILLW'(SIZE - 1));
        w_frame_wrap = (r_fcnt == FW'(FRAME - 1));
        w_cand       = in_valid && w_frame_wrap
                       && ((r_state == ST_RUN) || w_fill_last);
        w_fire       = w_cand && !busy;
        w_drop       = w_cand && busy;
    end

    // Fill/run next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (in_valid && w_fill_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write port: registered copy of the accepted sample at the current pointer.
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= in_valid;
            if (in_valid) begin
                r_waddr <= r_ptr;
                r_wdata <= in_data;
                r_ptr   <= r_ptr + AW'(1);
            end
        end
    end

    // Fill counter saturating at SIZE and free-running frame counter mod FRAME.
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_fill <= '0;
            r_fcnt <= '0;
        end else if (in_valid) begin
            if (r_fill != FILLW'(SIZE)) begin
                r_fill <= r_fill + FILLW'(1);
            end
            if (w_frame_wrap) begin
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    // Frame pulse and window base; base is the slot after the newest sample.
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_frame <= 1'b0;
            r_base  <= '0;
        end else begin
            r_frame <= w_fire;
            if (w_fire) begin
                r_base <= r_ptr + AW'(1);
            end
        end
    end

    // Drop status; a drop coinciding with a clear restarts the count at one.
    always_ff @(posedge ck) begin
        if (!rst) begin
            r_dropped  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_dropped  <= 1'b1;
            r_drop_cnt <= clr_drop ? DROP_W'(1) : drop_sat_inc(r_drop_cnt);
        end else if (clr_drop) begin
            r_dropped  <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign frame    = r_frame;
    assign base     = r_base;
    assign dropped  = r_dropped;
    assign drop_cnt = r_drop_cnt;

endmodule
